// File: rtl/seven_seg_scan_ctrl.sv
// Seven-segment scan sequencer: buffers a short letter-code message and
// time-multiplexes one shared decoder across DIGITS common-anode digits.
module seven_seg_scan_ctrl #(
    parameter int DIGITS        = 4,
    parameter int MSG_LEN       = 8,
    parameter int REFRESH_DIV   = 1000,
    parameter int SCROLL_FRAMES = 100
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         start,
    input  logic                         scroll_en,
    input  logic                         wr_valid,
    input  logic [2:0]                   wr_data,
    output logic                         wr_ready,
    output logic [2:0]                   bin,
    output logic [DIGITS-1:0]            dig_en_n,
    output logic                         running,
    output logic [$clog2(MSG_LEN+1)-1:0] msg_len,
    output logic                         frame_tick
);

    localparam int LW = $clog2(MSG_LEN + 1);
    localparam int PW = $clog2(MSG_LEN);
    localparam int SW = $clog2(DIGITS);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int FW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

    typedef enum logic {LOAD, RUN} state_t;

    state_t            state, state_nxt;
    logic [2:0]        msg_buf [MSG_LEN];
    logic [PW-1:0]     ptr, ptr_nxt;
    logic [PW-1:0]     offset, offset_nxt;
    logic [SW-1:0]     slot, slot_nxt;
    logic [RW-1:0]     refresh_cnt, refresh_nxt;
    logic [FW-1:0]     frame_cnt, frame_nxt;
    logic [LW-1:0]     msg_len_nxt;
    logic              wr_fire;
    logic              tick_nxt;
    logic [2:0]        bin_nxt;
    logic [DIGITS-1:0] dig_nxt;

    // Advance a buffer index by one, wrapping at the current message length.
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p, input logic [LW-1:0] len);
        logic [LW-1:0] inc;
        inc = LW'(p) + LW'(1);
        return (inc >= len) ? '0 : PW'(inc);
    endfunction

    assign wr_ready = (state == LOAD) && (msg_len < LW'(MSG_LEN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_nxt;
    end

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        state_nxt   = state;
        msg_len_nxt = msg_len;
        offset_nxt  = offset;
        ptr_nxt     = ptr;
        slot_nxt    = slot;
        refresh_nxt = refresh_cnt;
        frame_nxt   = frame_cnt;
        tick_nxt    = 1'b0;
        wr_fire     = 1'b0;

        if (clear) begin
            state_nxt   = LOAD;
            msg_len_nxt = '0;
            offset_nxt  = '0;
            ptr_nxt     = '0;
            slot_nxt    = '0;
            refresh_nxt = '0;
            frame_nxt   = '0;
        end else begin
            case (state)
                LOAD: begin
                    wr_fire = wr_valid && wr_ready;
                    if (wr_fire) msg_len_nxt = msg_len + LW'(1);
                    if (start && (msg_len != '0 || wr_fire)) begin
                        state_nxt   = RUN;
                        offset_nxt  = '0;
                        ptr_nxt     = '0;
                        slot_nxt    = '0;
                        refresh_nxt = '0;
                        frame_nxt   = '0;
                    end
                end
                RUN: begin
                    if (refresh_cnt == RW'(REFRESH_DIV - 1)) begin
                        refresh_nxt = '0;
                        if (slot == SW'(DIGITS - 1)) begin
                            slot_nxt = '0;
                            tick_nxt = 1'b1;
                            if (frame_cnt == FW'(SCROLL_FRAMES - 1)) begin
                                frame_nxt = '0;
                                if (scroll_en) offset_nxt = wrap_inc(offset, msg_len);
                            end else begin
                                frame_nxt = frame_cnt + FW'(1);
                            end
                            // The scrolled offset takes effect on this same slot-0 reload.
                            ptr_nxt = offset_nxt;
                        end else begin
                            slot_nxt = slot + SW'(1);
                            ptr_nxt  = wrap_inc(ptr, msg_len);
                        end
                    end else begin
                        refresh_nxt = refresh_cnt + RW'(1);
                    end
                end
                default: state_nxt = LOAD;
            endcase
        end

        // Outputs are registered from next-state values; a code written on the
        // start cycle is forwarded so the first slot shows it immediately.
        bin_nxt = '0;
        dig_nxt = '1;
        if (state_nxt == RUN) begin
            bin_nxt = (wr_fire && msg_len[PW-1:0] == ptr_nxt) ? wr_data : msg_buf[ptr_nxt];
            if (refresh_nxt != '0) dig_nxt = ~(DIGITS'(1) << slot_nxt);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the message buffer is reset as well, so a fresh scan never shows stale codes.
            for (int i = 0; i < MSG_LEN; i++) msg_buf[i] <= '0;
            msg_len     <= '0;
            offset      <= '0;
            ptr         <= '0;
            slot        <= '0;
            refresh_cnt <= '0;
            frame_cnt   <= '0;
            bin         <= '0;
            dig_en_n    <= '1;
            running     <= 1'b0;
            frame_tick  <= 1'b0;
        end else begin
            if (wr_fire) msg_buf[msg_len[PW-1:0]] <= wr_data;
            msg_len     <= msg_len_nxt;
            offset      <= offset_nxt;
            ptr         <= ptr_nxt;
            slot        <= slot_nxt;
            refresh_cnt <= refresh_nxt;
            frame_cnt   <= frame_nxt;
            bin         <= bin_nxt;
            dig_en_n    <= dig_nxt;
            running     <= (state_nxt == RUN);
            frame_tick  <= tick_nxt;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with a fast refresh (4 cycles/slot, 2 frames/step).
module tb_seven_seg_scan_ctrl;

    logic       clk, rst_n, clear, start, scroll_en, wr_valid;
    logic [2:0] wr_data, bin;
    logic       wr_ready, running, frame_tick;
    logic [3:0] dig_en_n;
    logic [3:0] msg_len;

    int n_checks = 0;
    int n_fail   = 0;

    seven_seg_scan_ctrl #(
        .DIGITS(4), .MSG_LEN(8), .REFRESH_DIV(4), .SCROLL_FRAMES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .start(start), .scroll_en(scroll_en),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready), .bin(bin),
        .dig_en_n(dig_en_n), .running(running), .msg_len(msg_len), .frame_tick(frame_tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write_code(input logic [2:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    // One full frame starting at slot 0, first cycle; leaves the bench at the next frame start.
    task automatic check_frame(input logic [2:0] e0, e1, e2, e3, input logic tick_exp, input string tag);
        logic [2:0] exp_bin [4];
        logic [3:0] exp_dig;
        logic       exp_tick;
        exp_bin = '{e0, e1, e2, e3};
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 4; c++) begin
                exp_dig  = (c == 0) ? 4'b1111 : ~(4'b0001 << s);
                exp_tick = (s == 0 && c == 0) ? tick_exp : 1'b0;
                n_checks++;
                if (bin !== exp_bin[s]) begin
                    n_fail++;
                    $display("FAIL %s bin slot %0d cyc %0d: got %0d expected %0d", tag, s, c, bin, exp_bin[s]);
                end
                n_checks++;
                if (dig_en_n !== exp_dig) begin
                    n_fail++;
                    $display("FAIL %s dig_en_n slot %0d cyc %0d: got %b expected %b", tag, s, c, dig_en_n, exp_dig);
                end
                n_checks++;
                if (frame_tick !== exp_tick) begin
                    n_fail++;
                    $display("FAIL %s frame_tick slot %0d cyc %0d: got %b expected %b", tag, s, c, frame_tick, exp_tick);
                end
                step();
            end
        end
    endtask

    task automatic check_idle(input string tag);
        n_checks++;
        if (bin !== 3'd0) begin n_fail++; $display("FAIL %s bin: got %0d expected 0", tag, bin); end
        n_checks++;
        if (dig_en_n !== 4'b1111) begin n_fail++; $display("FAIL %s dig_en_n: got %b expected 1111", tag, dig_en_n); end
        n_checks++;
        if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL %s wr_ready: got %b expected 1", tag, wr_ready); end
        n_checks++;
        if (running !== 1'b0) begin n_fail++; $display("FAIL %s running: got %b expected 0", tag, running); end
        n_checks++;
        if (msg_len !== 4'd0) begin n_fail++; $display("FAIL %s msg_len: got %0d expected 0", tag, msg_len); end
        n_checks++;
        if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL %s frame_tick: got %b expected 0", tag, frame_tick); end
    endtask

    task automatic check_run(input logic [3:0] len_exp, input string tag);
        n_checks++;
        if (running !== 1'b1) begin n_fail++; $display("FAIL %s running: got %b expected 1", tag, running); end
        n_checks++;
        if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL %s wr_ready: got %b expected 0", tag, wr_ready); end
        n_checks++;
        if (msg_len !== len_exp) begin n_fail++; $display("FAIL %s msg_len: got %0d expected %0d", tag, msg_len, len_exp); end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_idle("reset_initial");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_idle("after_reset");
    endtask

    task automatic test_load_scan();
        write_code(3'd0);
        write_code(3'd1);
        write_code(3'd2);
        n_checks++;
        if (msg_len !== 4'd3) begin n_fail++; $display("FAIL load msg_len: got %0d expected 3", msg_len); end
        pulse_start();
        check_run(4'd3, "load_run");
        check_frame(3'd0, 3'd1, 3'd2, 3'd0, 1'b0, "scan_f0");
        check_frame(3'd0, 3'd1, 3'd2, 3'd0, 1'b1, "scan_f1");
        check_frame(3'd0, 3'd1, 3'd2, 3'd0, 1'b1, "noscroll_f2");
        check_frame(3'd0, 3'd1, 3'd2, 3'd0, 1'b1, "noscroll_f3");
    endtask

    task automatic test_reset_midrun();
        step();
        #2 rst_n = 1'b0;
        #1 check_idle("reset_midrun");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_idle("after_midrun_reset");
    endtask

    task automatic test_scroll();
        write_code(3'd0);
        write_code(3'd1);
        write_code(3'd2);
        scroll_en = 1'b1;
        pulse_start();
        check_run(4'd3, "scroll_run");
        check_frame(3'd0, 3'd1, 3'd2, 3'd0, 1'b0, "scroll_f0");
        check_frame(3'd0, 3'd1, 3'd2, 3'd0, 1'b1, "scroll_f1");
        check_frame(3'd1, 3'd2, 3'd0, 3'd1, 1'b1, "scroll_f2");
        check_frame(3'd1, 3'd2, 3'd0, 3'd1, 1'b1, "scroll_f3");
        check_frame(3'd2, 3'd0, 3'd1, 3'd2, 1'b1, "scroll_f4");
        check_frame(3'd2, 3'd0, 3'd1, 3'd2, 1'b1, "scroll_f5");
        check_frame(3'd0, 3'd1, 3'd2, 3'd0, 1'b1, "scroll_f6");
        scroll_en = 1'b0;
    endtask

    task automatic test_priority();
        step();
        clear = 1'b1;
        start = 1'b1;
        step();
        clear = 1'b0;
        start = 1'b0;
        check_idle("clear_over_start");
        clear    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 3'd4;
        step();
        clear    = 1'b0;
        wr_valid = 1'b0;
        check_idle("clear_over_write");
    endtask

    task automatic test_full_buffer();
        logic [2:0] seq [9];
        seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0, 3'd5};
        wr_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            wr_data = seq[i];
            n_checks++;
            if (wr_ready !== (i < 8)) begin
                n_fail++;
                $display("FAIL full wr_ready beat %0d: got %b expected %b", i, wr_ready, (i < 8));
            end
            step();
        end
        wr_valid = 1'b0;
        n_checks++;
        if (msg_len !== 4'd8) begin n_fail++; $display("FAIL full msg_len: got %0d expected 8", msg_len); end
        n_checks++;
        if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL full wr_ready after: got %b expected 0", wr_ready); end
        // Scroll to offset 5 so the window covers buf[5..7] and buf[0].
        scroll_en = 1'b1;
        pulse_start();
        check_run(4'd8, "full_run");
        repeat (160) step();
        check_frame(3'd5, 3'd6, 3'd0, 3'd0, 1'b1, "full_f10");
        scroll_en = 1'b0;
        pulse_clear();
        check_idle("full_cleared");
    endtask

    task automatic test_edge_starts();
        pulse_start();
        check_idle("start_empty");
        step();
        step();
        check_idle("start_empty_hold");
        wr_valid = 1'b1;
        wr_data  = 3'd5;
        start    = 1'b1;
        step();
        wr_valid = 1'b0;
        start    = 1'b0;
        check_run(4'd1, "write_and_start");
        check_frame(3'd5, 3'd5, 3'd5, 3'd5, 1'b0, "single_f0");
        check_frame(3'd5, 3'd5, 3'd5, 3'd5, 1'b1, "single_f1");
    endtask

    initial begin
        clear     = 1'b0;
        start     = 1'b0;
        scroll_en = 1'b0;
        wr_valid  = 1'b0;
        wr_data   = 3'd0;
        test_reset();
        test_load_scan();
        test_reset_midrun();
        test_scroll();
        test_priority();
        test_full_buffer();
        test_edge_starts();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
